platform_scheduler: RTL and testbench

Sequences the seven platform positions driven into the 640x480 VGA renderer. It accepts scroll requests from game logic and applies them only after a frame-start pulse. Updates are built in shadow registers during vertical blank and committed atomically, so the renderer never shows a partially scrolled frame. Platforms that scroll past the bottom of the game zone respawn at the top with a pseudo-random horizontal position.

---
 rtl/platform_scheduler_if.sv | 26 ++
 rtl/platform_scheduler.sv | 139 +++++++++++++
 tb/tb_platform_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/platform_scheduler_if.sv
// rtl/platform_scheduler_if.sv - scroll handshake and committed platform positions
interface platform_scheduler_if;
  logic       frame_start;
  logic       terminated;
  logic       scroll_req;
  logic [5:0] scroll_amt;
  logic       scroll_ack;
  logic [2:0] wrap_cnt;
  logic       busy;
  logic [9:0] p1_vpos, p2_vpos, p3_vpos, p4_vpos, p5_vpos, p6_vpos, p7_vpos;
  logic [9:0] p1_hpos, p2_hpos, p3_hpos, p4_hpos, p5_hpos, p6_hpos, p7_hpos;

  modport master (
    output frame_start, terminated, scroll_req, scroll_amt,
    input  scroll_ack, wrap_cnt, busy,
    input  p1_vpos, p2_vpos, p3_vpos, p4_vpos, p5_vpos, p6_vpos, p7_vpos,
    input  p1_hpos, p2_hpos, p3_hpos, p4_hpos, p5_hpos, p6_hpos, p7_hpos
  );

  modport slave (
    input  frame_start, terminated, scroll_req, scroll_amt,
    output scroll_ack, wrap_cnt, busy,
    output p1_vpos, p2_vpos, p3_vpos, p4_vpos, p5_vpos, p6_vpos, p7_vpos,
    output p1_hpos, p2_hpos, p3_hpos, p4_hpos, p5_hpos, p6_hpos, p7_hpos
  );
endinterface

// File: rtl/platform_scheduler.sv
// rtl/platform_scheduler.sv - frame-synchronous scroll of seven platforms
// Shadow positions are updated one per cycle in vblank, then committed at once.
module platform_scheduler #(
  parameter int          VTOP      = 31,
  parameter int          VBOT      = 511,
  parameter int          VSPAN     = 480,
  parameter int          HMIN      = 326,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                  pixel_clk,
  input logic                  rst,
  platform_scheduler_if.slave  bus
);

  localparam logic [9:0] VBOT_W  = 10'(VBOT);
  localparam logic [9:0] VSPAN_W = 10'(VSPAN);
  localparam logic [9:0] HMIN_W  = 10'(HMIN);
  localparam logic [9:0] INIT_H [7] = '{10'd340, 10'd460, 10'd380, 10'd520,
                                        10'd350, 10'd440, 10'd400};

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, UPDATE, COMMIT} state_t;

  state_t      state, next_state;
  logic        accept, start_upd, do_update, do_commit;
  logic [2:0]  idx;
  logic [5:0]  amt_q;
  logic [2:0]  wrap_q;
  logic [15:0] lfsr;
  logic [9:0]  shadow_v [7];
  logic [9:0]  shadow_h [7];
  logic [9:0]  out_v    [7];
  logic [9:0]  out_h    [7];
  logic [9:0]  sum;
  logic [7:0]  rnd;
  logic [9:0]  respawn_h;

  function automatic logic [9:0] init_v(input int i);
    return 10'(VTOP + 70 * i);
  endfunction

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    start_upd  = 1'b0;
    do_update  = 1'b0;
    do_commit  = 1'b0;
    case (state)
      IDLE: if (bus.scroll_req && !bus.terminated) begin
        accept     = 1'b1;
        next_state = WAIT_FRAME;
      end
      WAIT_FRAME: if (bus.frame_start) begin
        start_upd  = 1'b1;
        next_state = UPDATE;
      end
      UPDATE: begin
        do_update = 1'b1;
        if (idx == 3'd6) next_state = COMMIT;
      end
      COMMIT: begin
        do_commit  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Respawn columns fold 224..255 back by 32 so a 75-wide platform fits before hc 625.
  assign sum       = shadow_v[idx] + {4'd0, amt_q};
  assign rnd       = lfsr[7:0];
  assign respawn_h = HMIN_W + {2'd0, (rnd > 8'd223) ? rnd - 8'd32 : rnd};

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      lfsr           <= LFSR_SEED;
      idx            <= 3'd0;
      amt_q          <= 6'd0;
      wrap_q         <= 3'd0;
      bus.busy       <= 1'b0;
      bus.scroll_ack <= 1'b0;
      bus.wrap_cnt   <= 3'd0;
      for (int i = 0; i < 7; i++) begin
        shadow_v[i] <= init_v(i);
        shadow_h[i] <= INIT_H[i];
        out_v[i]    <= init_v(i);
        out_h[i]    <= INIT_H[i];
      end
    end else begin
      lfsr           <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      bus.scroll_ack <= 1'b0;
      if (accept) begin
        amt_q    <= bus.scroll_amt;
        wrap_q   <= 3'd0;
        bus.busy <= 1'b1;
      end
      if (start_upd) idx <= 3'd0;
      if (do_update) begin
        idx <= idx + 3'd1;
        if (sum > VBOT_W) begin
          shadow_v[idx] <= sum - VSPAN_W;
          shadow_h[idx] <= respawn_h;
          wrap_q        <= wrap_q + 3'd1;
        end else begin
          shadow_v[idx] <= sum;
        end
      end
      if (do_commit) begin
        for (int i = 0; i < 7; i++) begin
          out_v[i] <= shadow_v[i];
          out_h[i] <= shadow_h[i];
        end
        bus.wrap_cnt   <= wrap_q;
        bus.scroll_ack <= 1'b1;
        bus.busy       <= 1'b0;
      end
    end
  end

  assign bus.p1_vpos = out_v[0];
  assign bus.p2_vpos = out_v[1];
  assign bus.p3_vpos = out_v[2];
  assign bus.p4_vpos = out_v[3];
  assign bus.p5_vpos = out_v[4];
  assign bus.p6_vpos = out_v[5];
  assign bus.p7_vpos = out_v[6];
  assign bus.p1_hpos = out_h[0];
  assign bus.p2_hpos = out_h[1];
  assign bus.p3_hpos = out_h[2];
  assign bus.p4_hpos = out_h[3];
  assign bus.p5_hpos = out_h[4];
  assign bus.p6_hpos = out_h[5];
  assign bus.p7_hpos = out_h[6];

endmodule

// File: tb/tb_platform_scheduler.sv
// tb/tb_platform_scheduler.sv - directed self-checking bench for platform_scheduler
module tb_platform_scheduler;

  logic pixel_clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   ack_count = 0;
  int   acks0;

  platform_scheduler_if bus();

  platform_scheduler dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #20 pixel_clk = ~pixel_clk;

  always @(negedge pixel_clk) if (bus.scroll_ack === 1'b1) ack_count++;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Full request/frame/commit cycle with the documented F+8 latency.
  task automatic do_scroll(input logic [5:0] amt, input logic [9:0] old_p1,
                           input bit term_late, input string tag);
    int a0;
    a0 = ack_count;
    bus.scroll_req = 1'b1;
    bus.scroll_amt = amt;
    tick();
    chk({tag, "_busy_accept"}, bus.busy, 1);
    bus.scroll_amt = 6'h3f;
    if (term_late) bus.terminated = 1'b1;
    tick();
    tick();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    repeat (7) tick();
    chk({tag, "_p1_before_commit"}, bus.p1_vpos, old_p1);
    chk({tag, "_ack_early"}, bus.scroll_ack, 0);
    tick();
    chk({tag, "_ack"}, bus.scroll_ack, 1);
    chk({tag, "_busy_clear"}, bus.busy, 0);
    bus.scroll_req = 1'b0;
    tick();
    chk({tag, "_ack_pulse"}, bus.scroll_ack, 0);
    chk({tag, "_ack_once"}, ack_count, a0 + 1);
    bus.terminated = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.terminated  = 1'b0;
    bus.scroll_req  = 1'b0;
    bus.scroll_amt  = 6'd0;
    tick();
    tick();
    chk("rst_p1_v", bus.p1_vpos, 31);
    chk("rst_p7_v", bus.p7_vpos, 451);
    chk("rst_p4_h", bus.p4_hpos, 520);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.scroll_ack, 0);
    chk("rst_wrap", bus.wrap_cnt, 0);
    rst = 1'b0;
    tick();

    do_scroll(6'd10, 10'd31, 1'b0, "nowrap");
    chk("nowrap_p1_v", bus.p1_vpos, 41);
    chk("nowrap_p4_v", bus.p4_vpos, 251);
    chk("nowrap_p7_v", bus.p7_vpos, 461);
    chk("nowrap_wrap", bus.wrap_cnt, 0);
    chk("nowrap_p4_h", bus.p4_hpos, 520);
    chk("nowrap_p7_h", bus.p7_hpos, 400);

    acks0 = ack_count;
    bus.scroll_req = 1'b1;
    bus.scroll_amt = 6'd20;
    tick();
    bus.scroll_req = 1'b0;
    tick();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("midrst_p1_v", bus.p1_vpos, 31);
    chk("midrst_p7_v", bus.p7_vpos, 451);
    chk("midrst_busy", bus.busy, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("midrst_no_ack", ack_count, acks0);
    chk("midrst_p1_hold", bus.p1_vpos, 31);
    do_scroll(6'd10, 10'd31, 1'b0, "after_rst");
    chk("after_rst_p1_v", bus.p1_vpos, 41);
    chk("after_rst_p7_v", bus.p7_vpos, 461);

    reset_pulse();
    do_scroll(6'd63, 10'd31, 1'b0, "wrap");
    chk("wrap_p1_v", bus.p1_vpos, 94);
    chk("wrap_p6_v", bus.p6_vpos, 444);
    chk("wrap_p7_v", bus.p7_vpos, 34);
    chk("wrap_cnt", bus.wrap_cnt, 1);
    chk("wrap_p7_h_range", (bus.p7_hpos >= 10'd326 && bus.p7_hpos <= 10'd549), 1);
    chk("wrap_p6_h", bus.p6_hpos, 440);
    repeat (3) tick();
    chk("wrap_cnt_hold", bus.wrap_cnt, 1);

    reset_pulse();
    do_scroll(6'd60, 10'd31, 1'b0, "edge511");
    chk("edge511_p7_v", bus.p7_vpos, 511);
    chk("edge511_wrap", bus.wrap_cnt, 0);
    chk("edge511_p7_h", bus.p7_hpos, 400);
    do_scroll(6'd1, 10'd91, 1'b0, "edge512");
    chk("edge512_p1_v", bus.p1_vpos, 92);
    chk("edge512_p6_v", bus.p6_vpos, 442);
    chk("edge512_p7_v", bus.p7_vpos, 32);
    chk("edge512_wrap", bus.wrap_cnt, 1);

    acks0 = ack_count;
    bus.terminated = 1'b1;
    bus.scroll_req = 1'b1;
    bus.scroll_amt = 6'd5;
    tick();
    chk("term_busy", bus.busy, 0);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    repeat (10) tick();
    chk("term_busy_late", bus.busy, 0);
    chk("term_no_ack", ack_count, acks0);
    chk("term_p1_v", bus.p1_vpos, 92);
    bus.scroll_req = 1'b0;
    bus.terminated = 1'b0;
    tick();
    do_scroll(6'd5, 10'd92, 1'b1, "term_late");
    chk("term_late_p1_v", bus.p1_vpos, 97);
    chk("term_late_p7_v", bus.p7_vpos, 37);

    acks0 = ack_count;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    repeat (10) tick();
    chk("idle_frame_p1_v", bus.p1_vpos, 97);
    chk("idle_frame_no_ack", ack_count, acks0);
    chk("idle_frame_busy", bus.busy, 0);
    do_scroll(6'd0, 10'd97, 1'b0, "zero");
    chk("zero_p1_v", bus.p1_vpos, 97);
    chk("zero_p7_v", bus.p7_vpos, 37);
    chk("zero_wrap", bus.wrap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
